tetris_vga_render: RTL
======================

# tetris_vga_render

Downstream display stage for the Tetris core. Consumes the 200-bit playfield vector `blocks` (10 columns × 20 rows) and drives a 640×480 @ 60 Hz VGA monitor: the field is drawn as 16×16-pixel cells inside a grey border. Includes a per-frame snapshot so the picture never tears mid-frame, and a `frame_tick` pulse the game logic can use as a gravity/time base.

## Interface
- `CLK_DIV`, 4, Clk cycles per pixel tick (100 MHz board clock → 25 MHz pixel rate)
- `FIELD_X0`, 240, screen x of the field's left edge
- `FIELD_Y0`, 80, screen y of the field's top edge
- `Clk`  in  1  system clock; all logic on its rising edge
- `Reset`  in  1  one clock; reset is synchronous and active-low (`Reset`=0 resets on the next `Clk` edge)
- `blocks`  in  200  playfield; bit index = row*10 + col, row 0 = bottom, row 19 = top, col 0 = left
- `hSync`  out  1  horizontal sync, active low
- `vSync`  out  1  vertical sync, active low
- `vgaRed`  out  3  red level
- `vgaGreen`  out  3  green level
- `vgaBlue`  out  2  blue level
- `frame_tick`  out  1  one-`Clk` pulse at the start of vertical blank

## Operation
- Pixel tick: `div_cnt` counts 0..CLK_DIV-1; tick when `div_cnt`==CLK_DIV-1. All counters and outputs update only on ticks (except `frame_tick`, which is one `Clk` wide).
- `hc` 0..799: visible 0–639, front porch 640–655, sync 656–751, back porch 752–799. `vc` 0..524 increments when `hc` wraps 799→0: visible 0–479, front porch 480–489, sync 490–491, back porch 492–524; `vc` wraps 524→0.
- Snapshot: on the tick where `hc`==0 and `vc`==480, `shadow` <= `blocks` and `frame_tick` pulses. Display reads `shadow` only; `blocks` changes inside a frame are invisible until the next frame.
- Pixel classification (visible region only, else black):
  - field: FIELD_X0 ≤ hc < FIELD_X0+160 and FIELD_Y0 ≤ vc < FIELD_Y0+320. cx = (hc−FIELD_X0)>>4 (0..9), cy = (vc−FIELD_Y0)>>4 (0..19), index = (19−cy)*10 + cx. If `shadow[index]`=1: cyan (R0 G7 B3), except pixels with x-offset or y-offset within the cell = 0 → black (grid line). If 0: black.
  - border: within 4 px outside the field rectangle (x 236–403, y 76–403, not field) → grey (R3 G3 B1).
  - everything else → black.
- Index arithmetic is 8-bit unsigned; (19−cy)*10 is computed as constant multiply/shift-add, no generic multiplier.

## Timing
- Reset values: `div_cnt`=0, `hc`=0, `vc`=0, `shadow`=0, `hSync`=1, `vSync`=1, all colour outputs 0, `frame_tick`=0.
- Output latency: colours and syncs are registered together; the values for counter position (hc,vc) appear one pixel tick after the counters reach (hc,vc). Syncs and colours stay mutually aligned.
- `hSync` low exactly 96 ticks per line; line = 800 ticks; `vSync` low exactly 2 lines (1600 ticks); frame = 525 lines = 420 000 ticks.
- `frame_tick`: exactly one `Clk` high per frame, in the `Clk` cycle of the snapshot tick.
- Reset mid-frame: next `Clk` edge with `Reset`=0 restores all reset values; after release, timing restarts from hc=vc=0 and the first snapshot occurs at vc=480 (field shows empty until then).

## Structure
- Shared package `tetris_pkg`: grid constants (COLS=10, ROWS=20, CELL=16), VGA timing constants (H/V visible, porch, sync, total), colour constants (CYAN, GREY, BLACK).
- One sub-module `vga_sync_gen`: pixel-tick divider, `hc`/`vc` counters, raw sync and visible flags. Top level holds snapshot, cell lookup and output registers.

## Test plan
- Reset held low 5 Clk, release → hSync=vSync=1, colours 0, frame_tick=0; first hSync falls (656+1)×4 Clk after release.
- Run 2 frames → hSync period 3200 Clk, low 384 Clk; vSync low 6400 Clk per 1 680 000 Clk; frame_tick exactly once per frame.
- blocks[194]=1 only → cyan at x 305–319, y 81–95; black at x=304 / y=80 grid lines; all other field pixels black.
- blocks[0]=1 → cyan at x 241–255, y 385–399; border pixel (238,200) grey; (100,100) black.
- Toggle blocks[194] at vc=200 → current frame unchanged; change appears from the following frame.
- Reset pulsed low at vc=300 → outputs return to reset values next edge; counters restart at 0; field empty until vc=480.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared constants for the Tetris display path:
// playfield grid, VGA 640x480 timing and palette.
package tetris_pkg;

   localparam int COLS    = 10;
   localparam int ROWS    = 20;
   localparam int CELL    = 16;
   localparam int BORDER  = 4;
   localparam int FIELD_W = COLS * CELL;
   localparam int FIELD_H = ROWS * CELL;

   localparam int H_VIS  = 640;
   localparam int H_FP   = 16;
   localparam int H_SYNC = 96;
   localparam int H_BP   = 48;

   localparam int V_VIS  = 480;
   localparam int V_FP   = 10;
   localparam int V_SYNC = 2;
   localparam int V_BP   = 33;

   localparam int CW = 10;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } rgb_t;

   localparam rgb_t BLACK = '{r: 3'd0, g: 3'd0, b: 2'd0};
   localparam rgb_t CYAN  = '{r: 3'd0, g: 3'd7, b: 2'd3};
   localparam rgb_t GREY  = '{r: 3'd3, g: 3'd3, b: 2'd1};

   // Row 0 is the bottom of the field while screen row 0
   // is the top, hence the flip; x10 done as x8 + x2.
   function automatic logic [7:0] cell_index(
      input logic [4:0] cy,
      input logic [3:0] cx
   );
      logic [4:0] r;
      r = 5'd19 - cy;
      return {r, 3'b000}
           + {2'b00, r, 1'b0}
           + {4'b0000, cx};
   endfunction

endpackage

// File: rtl/vga_sync_gen.sv
// Pixel-tick divider plus horizontal/vertical
// counters with raw syncs and visible flag.
module vga_sync_gen
   import tetris_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int HVIS    = H_VIS,
   parameter int HFP     = H_FP,
   parameter int HSYNC   = H_SYNC,
   parameter int HBP     = H_BP,
   parameter int VVIS    = V_VIS,
   parameter int VFP     = V_FP,
   parameter int VSYNC   = V_SYNC,
   parameter int VBP     = V_BP
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   output logic          tick_o,
   output logic [CW-1:0] hc_o,
   output logic [CW-1:0] vc_o,
   output logic          hsync_o,
   output logic          vsync_o,
   output logic          vis_o
);

   localparam int HTOT = HVIS + HFP + HSYNC + HBP;
   localparam int VTOT = VVIS + VFP + VSYNC + VBP;
   localparam int DW   =
      (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_ONE = DW'(1);

   localparam logic [CW-1:0] H_MAX  = CW'(HTOT - 1);
   localparam logic [CW-1:0] V_MAX  = CW'(VTOT - 1);
   localparam logic [CW-1:0] H_END  = CW'(HVIS);
   localparam logic [CW-1:0] V_END  = CW'(VVIS);
   localparam logic [CW-1:0] HS_ON  = CW'(HVIS + HFP);
   localparam logic [CW-1:0] HS_OFF =
      CW'(HVIS + HFP + HSYNC);
   localparam logic [CW-1:0] VS_ON  = CW'(VVIS + VFP);
   localparam logic [CW-1:0] VS_OFF =
      CW'(VVIS + VFP + VSYNC);

   logic [DW-1:0] div_q, div_d;
   logic [CW-1:0] hc_q, hc_d;
   logic [CW-1:0] vc_q, vc_d;
   logic          tick;

   // Counter registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         div_q <= '0;
         hc_q  <= '0;
         vc_q  <= '0;
      end else begin
         div_q <= div_d;
         hc_q  <= hc_d;
         vc_q  <= vc_d;
      end
   end

   // Next-state: divider always runs, raster advances on ticks.
   always_comb begin
      tick  = (div_q == DIV_MAX);
      div_d = tick ? '0 : div_q + DIV_ONE;
      hc_d  = hc_q;
      vc_d  = vc_q;
      if (tick) begin
         if (hc_q == H_MAX) begin
            hc_d = '0;
            vc_d = (vc_q == V_MAX) ? '0 : vc_q + 1'b1;
         end else begin
            hc_d = hc_q + 1'b1;
         end
      end
   end

   assign tick_o  = tick;
   assign hc_o    = hc_q;
   assign vc_o    = vc_q;
   assign hsync_o = !((hc_q >= HS_ON) && (hc_q < HS_OFF));
   assign vsync_o = !((vc_q >= VS_ON) && (vc_q < VS_OFF));
   assign vis_o   = (hc_q < H_END) && (vc_q < V_END);

endmodule

// File: rtl/tetris_vga_render.sv
// Renders the 10x20 playfield as 16px cells in a grey
// frame, from a per-frame snapshot of the block map.
module tetris_vga_render
   import tetris_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int FIELD_X0 = 240,
   parameter int FIELD_Y0 = 80,
   parameter int HVIS     = H_VIS,
   parameter int HFP      = H_FP,
   parameter int HSYNC    = H_SYNC,
   parameter int HBP      = H_BP,
   parameter int VVIS     = V_VIS,
   parameter int VFP      = V_FP,
   parameter int VSYNC    = V_SYNC,
   parameter int VBP      = V_BP
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic [199:0] blocks,
   output logic         hSync,
   output logic         vSync,
   output logic [2:0]   vgaRed,
   output logic [2:0]   vgaGreen,
   output logic [1:0]   vgaBlue,
   output logic         frame_tick
);

   localparam logic [CW-1:0] FX0 = CW'(FIELD_X0);
   localparam logic [CW-1:0] FY0 = CW'(FIELD_Y0);
   localparam logic [CW-1:0] BX0 = CW'(FIELD_X0 - BORDER);
   localparam logic [CW-1:0] BY0 = CW'(FIELD_Y0 - BORDER);
   localparam logic [CW-1:0] FW  = CW'(FIELD_W);
   localparam logic [CW-1:0] FH  = CW'(FIELD_H);
   localparam logic [CW-1:0] BW  = CW'(FIELD_W + 2 * BORDER);
   localparam logic [CW-1:0] BH  = CW'(FIELD_H + 2 * BORDER);
   localparam logic [CW-1:0] SNAP_V = CW'(VVIS);

   logic          tick;
   logic [CW-1:0] hc;
   logic [CW-1:0] vc;
   logic          hs_raw;
   logic          vs_raw;
   logic          vis;

   vga_sync_gen #(
      .CLK_DIV (CLK_DIV),
      .HVIS    (HVIS),
      .HFP     (HFP),
      .HSYNC   (HSYNC),
      .HBP     (HBP),
      .VVIS    (VVIS),
      .VFP     (VFP),
      .VSYNC   (VSYNC),
      .VBP     (VBP)
   ) u_sync (
      .clk_i   (Clk),
      .rst_ni  (Reset),
      .tick_o  (tick),
      .hc_o    (hc),
      .vc_o    (vc),
      .hsync_o (hs_raw),
      .vsync_o (vs_raw),
      .vis_o   (vis)
   );

   logic [199:0]  shadow_q, shadow_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   rgb_t          rgb_q, rgb_d;
   logic          ftick_q, ftick_d;

   logic          snap;
   logic [CW-1:0] dx, dy;
   logic [CW-1:0] bdx, bdy;
   logic          in_field;
   logic          in_box;
   logic          grid;
   logic          cell_on;
   rgb_t          pix_rgb;

   // Offsets wrap below the origin, so a single unsigned
   // compare against the width tests both edges at once.
   always_comb begin
      dx       = hc - FX0;
      dy       = vc - FY0;
      bdx      = hc - BX0;
      bdy      = vc - BY0;
      in_field = (dx < FW) && (dy < FH);
      in_box   = (bdx < BW) && (bdy < BH);
      grid     = (dx[3:0] == 4'd0) || (dy[3:0] == 4'd0);
      cell_on  = shadow_q[cell_index(dy[8:4], dx[7:4])];
   end

   // Colour of the pixel at the current raster position.
   always_comb begin
      pix_rgb = BLACK;
      if (vis) begin
         if (in_field) begin
            if (cell_on && !grid) pix_rgb = CYAN;
         end else if (in_box) begin
            pix_rgb = GREY;
         end
      end
   end

   // Snapshot at the top of vertical blank; outputs on ticks.
   always_comb begin
      snap     = tick && (hc == '0) && (vc == SNAP_V);
      shadow_d = snap ? blocks : shadow_q;
      ftick_d  = snap;
      hsync_d  = tick ? hs_raw  : hsync_q;
      vsync_d  = tick ? vs_raw  : vsync_q;
      rgb_d    = tick ? pix_rgb : rgb_q;
   end

   // Output and snapshot registers.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         shadow_q <= '0;
         hsync_q  <= 1'b1;
         vsync_q  <= 1'b1;
         rgb_q    <= BLACK;
         ftick_q  <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         rgb_q    <= rgb_d;
         ftick_q  <= ftick_d;
      end
   end

   assign hSync      = hsync_q;
   assign vSync      = vsync_q;
   assign vgaRed     = rgb_q.r;
   assign vgaGreen   = rgb_q.g;
   assign vgaBlue    = rgb_q.b;
   assign frame_tick = ftick_q;

endmodule
